// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with TX/RX FIFOs, run-time baud divisor and sticky error flags (8N1).
// Define UART_PARITY_EN to compile in the optional parity bit (CTRL[3:2], STATUS[7]).
module uart_fifo_periph #(
    parameter int unsigned CLK_FREQUENCY = 50,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter int unsigned TX_DEPTH      = 16,
    parameter int unsigned RX_DEPTH      = 16
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        rx_pin,
    output logic        tx_pin,
    input  logic        write_valid,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic        read_valid,
    input  logic [31:0] read_address,
    output logic [31:0] read_data
);
    localparam int unsigned DIV_RESET = (CLK_FREQUENCY * 1000000) / BAUD_RATE;
    localparam logic [15:0] DIV_RST16 = 16'(DIV_RESET);
    localparam int unsigned TXA = $clog2(TX_DEPTH);
    localparam int unsigned RXA = $clog2(RX_DEPTH);
    localparam int unsigned TXL = TXA + 1;
    localparam int unsigned RXL = RXA + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

    // Bus decode
    logic       wsel, rsel;
    logic [1:0] widx, ridx;
    logic       data_wr_c, stat_wr_c, ctrl_wr_c, div_wr_c, data_rd_c;
    logic       unused_bits;

    assign wsel      = write_valid && (write_address[31:4] == BASE_ADDR[31:4]);
    assign rsel      = read_valid && (read_address[31:4] == BASE_ADDR[31:4]);
    assign widx      = write_address[3:2];
    assign ridx      = read_address[3:2];
    assign data_wr_c = wsel && (widx == 2'd0);
    assign stat_wr_c = wsel && (widx == 2'd1);
    assign ctrl_wr_c = wsel && (widx == 2'd2);
    assign div_wr_c  = wsel && (widx == 2'd3);
    assign data_rd_c = rsel && (ridx == 2'd0);
    assign unused_bits = &{1'b0, write_address[1:0], read_address[1:0], write_data[31:16]};

    // rx_pin synchroniser plus one extra stage for falling-edge detection
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) {rx_meta_q, rx_sync_q, rx_prev_q} <= 3'b111;
        else        {rx_meta_q, rx_sync_q, rx_prev_q} <= {rx_pin, rx_meta_q, rx_sync_q};
    end

    // Control, divisor and flush requests
    logic        tx_en_q, rx_en_q, tx_flush_q, rx_flush_q;
    logic [15:0] div_q;
    logic [3:0]  ctrl_bits;
`ifdef UART_PARITY_EN
    logic        par_en_q, par_odd_q;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tx_en_q    <= 1'b1;
            rx_en_q    <= 1'b1;
            tx_flush_q <= 1'b0;
            rx_flush_q <= 1'b0;
            div_q      <= DIV_RST16;
`ifdef UART_PARITY_EN
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
`endif
        end else begin
            tx_flush_q <= ctrl_wr_c && write_data[4];
            rx_flush_q <= ctrl_wr_c && write_data[5];
            if (ctrl_wr_c) begin
                tx_en_q   <= write_data[0];
                rx_en_q   <= write_data[1];
`ifdef UART_PARITY_EN
                par_en_q  <= write_data[2];
                par_odd_q <= write_data[3];
`endif
            end
            if (div_wr_c) div_q <= (write_data[15:0] < 16'd4) ? 16'd4 : write_data[15:0];
        end
    end

`ifdef UART_PARITY_EN
    assign ctrl_bits = {par_odd_q, par_en_q, rx_en_q, tx_en_q};
`else
    assign ctrl_bits = {2'b00, rx_en_q, tx_en_q};
`endif

    // TX FIFO
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TXA-1:0] tx_wr_q, tx_rd_q;
    logic [TXL-1:0] tx_level_q;
    logic           tx_full, tx_empty, tx_push_c, tx_pop_c, tx_ovf_c;

    assign tx_full   = (tx_level_q == TXL'(TX_DEPTH));
    assign tx_empty  = (tx_level_q == '0);
    assign tx_push_c = data_wr_c && !tx_flush_q && (!tx_full || tx_pop_c);
    assign tx_ovf_c  = data_wr_c && !tx_flush_q && tx_full && !tx_pop_c;

    always_ff @(posedge clk_in) begin
        if (tx_push_c) tx_mem[tx_wr_q] <= write_data[7:0];
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_level_q <= '0;
        end else if (tx_flush_q) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_level_q <= '0;
        end else begin
            if (tx_push_c) tx_wr_q <= tx_wr_q + TXA'(1);
            if (tx_pop_c)  tx_rd_q <= tx_rd_q + TXA'(1);
            if (tx_push_c && !tx_pop_c)      tx_level_q <= tx_level_q + TXL'(1);
            else if (!tx_push_c && tx_pop_c) tx_level_q <= tx_level_q - TXL'(1);
        end
    end

    // RX FIFO
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RXA-1:0] rx_wr_q, rx_rd_q;
    logic [RXL-1:0] rx_level_q;
    logic           rx_full, rx_empty, rx_pop_c, rx_push_c, rx_push_ok_c, rx_ovr_c;
    logic [7:0]     rx_shift_q, rx_shift_d;

    assign rx_full      = (rx_level_q == RXL'(RX_DEPTH));
    assign rx_empty     = (rx_level_q == '0);
    assign rx_pop_c     = data_rd_c && !rx_empty && !rx_flush_q;
    assign rx_push_ok_c = rx_push_c && !rx_flush_q && (!rx_full || rx_pop_c);
    assign rx_ovr_c     = rx_push_c && !rx_flush_q && rx_full && !rx_pop_c;

    always_ff @(posedge clk_in) begin
        if (rx_push_ok_c) rx_mem[rx_wr_q] <= rx_shift_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_level_q <= '0;
        end else if (rx_flush_q) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_level_q <= '0;
        end else begin
            if (rx_push_ok_c) rx_wr_q <= rx_wr_q + RXA'(1);
            if (rx_pop_c)     rx_rd_q <= rx_rd_q + RXA'(1);
            if (rx_push_ok_c && !rx_pop_c)      rx_level_q <= rx_level_q + RXL'(1);
            else if (!rx_push_ok_c && rx_pop_c) rx_level_q <= rx_level_q - RXL'(1);
        end
    end

    // TX engine: the divisor (and parity mode) are captured at the start bit
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_tick_q, tx_tick_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_pin_d, tx_last_c, tx_busy;
`ifdef UART_PARITY_EN
    logic        tx_pe_q, tx_pe_d, tx_par_q, tx_par_d;
`endif

    assign tx_busy = (tx_state_q != S_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop_c   = 1'b0;
        tx_pin_d   = 1'b1;
`ifdef UART_PARITY_EN
        tx_pe_d    = tx_pe_q;
        tx_par_d   = tx_par_q;
`endif
        tx_last_c  = (tx_tick_q == (tx_div_q - 16'd1));
        case (tx_state_q)
            S_IDLE: begin
                if (tx_en_q && !tx_empty && !tx_flush_q) begin
                    tx_pop_c   = 1'b1;
                    tx_shift_d = tx_mem[tx_rd_q];
                    tx_div_d   = div_q;
                    tx_tick_d  = 16'd0;
                    tx_state_d = S_START;
`ifdef UART_PARITY_EN
                    tx_pe_d    = par_en_q;
                    tx_par_d   = (^tx_mem[tx_rd_q]) ^ par_odd_q;
`endif
                end
            end
            S_START: begin
                tx_tick_d = tx_tick_q + 16'd1;
                if (tx_last_c) begin
                    tx_tick_d  = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_tick_d = tx_tick_q + 16'd1;
                if (tx_last_c) begin
                    tx_tick_d = 16'd0;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = tx_pe_q ? S_PARITY : S_STOP;
`else
                        tx_state_d = S_STOP;
`endif
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                tx_tick_d = tx_tick_q + 16'd1;
                if (tx_last_c) begin
                    tx_tick_d  = 16'd0;
                    tx_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                tx_tick_d = tx_tick_q + 16'd1;
                if (tx_last_c) begin
                    tx_tick_d  = 16'd0;
                    tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Line level follows the state being entered so tx_pin stays aligned with the state register
        case (tx_state_d)
            S_START:  tx_pin_d = 1'b0;
            S_DATA:   tx_pin_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_pin_d = tx_par_d;
`endif
            default:  tx_pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_tick_q  <= 16'd0;
            tx_div_q   <= DIV_RST16;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            tx_pin     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_pe_q    <= 1'b0;
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_pin     <= tx_pin_d;
`ifdef UART_PARITY_EN
            tx_pe_q    <= tx_pe_d;
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // RX engine: start validated at mid-bit, then one sample per bit period
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_tick_q, rx_tick_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_last_c, rx_ferr_c, rx_perr_c;
`ifdef UART_PARITY_EN
    logic        rx_pe_q, rx_pe_d, rx_po_q, rx_po_d, rx_pbit_q, rx_pbit_d;
`else
    assign rx_perr_c = 1'b0;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push_c  = 1'b0;
        rx_ferr_c  = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_c  = 1'b0;
        rx_pe_d    = rx_pe_q;
        rx_po_d    = rx_po_q;
        rx_pbit_d  = rx_pbit_q;
`endif
        rx_last_c  = (rx_tick_q == (rx_div_q - 16'd1));
        case (rx_state_q)
            S_IDLE: begin
                if (rx_en_q && rx_prev_q && !rx_sync_q) begin
                    rx_tick_d  = 16'd0;
                    rx_div_d   = div_q;
                    rx_state_d = S_START;
`ifdef UART_PARITY_EN
                    rx_pe_d    = par_en_q;
                    rx_po_d    = par_odd_q;
`endif
                end
            end
            S_START: begin
                rx_tick_d = rx_tick_q + 16'd1;
                if (rx_tick_q == (rx_div_q >> 1)) begin
                    rx_tick_d  = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                rx_tick_d = rx_tick_q + 16'd1;
                if (rx_last_c) begin
                    rx_tick_d  = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = rx_pe_q ? S_PARITY : S_STOP;
`else
                        rx_state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                rx_tick_d = rx_tick_q + 16'd1;
                if (rx_last_c) begin
                    rx_tick_d  = 16'd0;
                    rx_pbit_d  = rx_sync_q;
                    rx_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                rx_tick_d = rx_tick_q + 16'd1;
                if (rx_last_c) begin
                    rx_tick_d  = 16'd0;
                    rx_state_d = S_IDLE;
                    if (!rx_sync_q) rx_ferr_c = 1'b1;
`ifdef UART_PARITY_EN
                    else if (rx_pe_q && (rx_pbit_q != ((^rx_shift_q) ^ rx_po_q))) rx_perr_c = 1'b1;
`endif
                    else rx_push_c = 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= S_IDLE;
            rx_tick_q  <= 16'd0;
            rx_div_q   <= DIV_RST16;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
`ifdef UART_PARITY_EN
            rx_pe_q    <= 1'b0;
            rx_po_q    <= 1'b0;
            rx_pbit_q  <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
`ifdef UART_PARITY_EN
            rx_pe_q    <= rx_pe_d;
            rx_po_q    <= rx_po_d;
            rx_pbit_q  <= rx_pbit_d;
`endif
        end
    end

    // Sticky flags {tx_overflow, parity_err, frame_err, rx_overrun}; a same-cycle set beats W1C
    logic [3:0]  flags_q, flag_set_c, flag_clr_c;
    logic [31:0] status_word;

    assign flag_set_c = {tx_ovf_c, rx_perr_c, rx_ferr_c, rx_ovr_c};
    assign flag_clr_c = stat_wr_c ? write_data[8:5] : 4'd0;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) flags_q <= 4'd0;
        else        flags_q <= (flags_q & ~flag_clr_c) | flag_set_c;
    end

    // Bit 3 is set while no received byte is waiting (reset STATUS reads 0xA)
    assign status_word = {8'd0, 8'(rx_level_q), 7'd0, flags_q, tx_busy, rx_empty, rx_full,
                          tx_empty, tx_full};

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            read_data <= 32'd0;
        end else if (rsel) begin
            case (ridx)
                2'd0:    read_data <= rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_q]};
                2'd1:    read_data <= status_word;
                2'd2:    read_data <= {28'd0, ctrl_bits};
                default: read_data <= {16'd0, div_q};
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// Randomised self-checking bench for uart_fifo_periph: bus tasks, serial capture/drive,
// and a queue-based model of the RX FIFO contents and sticky flags.
module tb_uart_fifo_periph;
    localparam logic [31:0] A_DATA = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;
    localparam logic [31:0] A_CTRL = 32'h1000_0008;
    localparam logic [31:0] A_DIV  = 32'h1000_000C;
    localparam int unsigned DEPTH  = 16;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_valid = 1'b0;
    logic [31:0] write_address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        read_valid = 1'b0;
    logic [31:0] read_address = 32'd0;
    logic [31:0] read_data;
    logic        tx_pin;
    logic        loopback = 1'b0;
    logic        rx_drive = 1'b1;
    logic        rx_line;

    int          checks = 0;
    int          errors = 0;
    int          div_cur = 434;
    logic        par_on = 1'b0;
    logic [7:0]  exp_q[$];

    assign rx_line = loopback ? tx_pin : rx_drive;

    uart_fifo_periph dut (
        .clk_in(clk_in), .rst_n(rst_n), .rx_pin(rx_line), .tx_pin(tx_pin),
        .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
        .read_valid(read_valid), .read_address(read_address), .read_data(read_data)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk_in);
        write_valid = 1'b1; write_address = addr; write_data = data;
        @(negedge clk_in);
        write_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk_in);
        read_valid = 1'b1; read_address = addr;
        @(negedge clk_in);
        read_valid = 1'b0;
        data = read_data;
    endtask

    task automatic wait_tx_idle(input string tag);
        logic [31:0] st;
        int n = 0;
        bus_read(A_STAT, st);
        while (!(st[1] && !st[4]) && n < 4000) begin
            bus_read(A_STAT, st);
            n++;
        end
        if (n >= 4000) check({tag, "_timeout"}, 32'd0, 32'd1);
        repeat (4) @(negedge clk_in);
    endtask

    // Samples one frame off tx_pin at mid-bit
    task automatic capture_frame(output logic [7:0] b, output logic par, output logic stop);
        int t = 0;
        b = 8'd0; par = 1'b0; stop = 1'b0;
        while (tx_pin !== 1'b0 && t < 5000) begin
            @(negedge clk_in);
            t++;
        end
        if (t >= 5000) begin
            check("capture_timeout", 32'd0, 32'd1);
        end else begin
            repeat (div_cur / 2) @(negedge clk_in);
            check("cap_start_bit", {31'd0, tx_pin}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (div_cur) @(negedge clk_in);
                b[i] = tx_pin;
            end
            if (par_on) begin
                repeat (div_cur) @(negedge clk_in);
                par = tx_pin;
            end
            repeat (div_cur) @(negedge clk_in);
            stop = tx_pin;
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic with_par, input logic pbit,
                               input logic stop);
        @(negedge clk_in);
        rx_drive = 1'b0;
        repeat (div_cur) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rx_drive = b[i];
            repeat (div_cur) @(negedge clk_in);
        end
        if (with_par) begin
            rx_drive = pbit;
            repeat (div_cur) @(negedge clk_in);
        end
        rx_drive = stop;
        repeat (div_cur) @(negedge clk_in);
        rx_drive = 1'b1;
        repeat (2 * div_cur) @(negedge clk_in);
    endtask

    initial begin
        logic [31:0] st, d;
        logic [7:0]  b, cb;
        logic        cp, cs;
        int          k;

        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_tx_pin", {31'd0, tx_pin}, 32'd1);
        check("rst_read_data", read_data, 32'd0);
        rst_n = 1'b1;
        bus_read(A_STAT, st);
        check("rst_status", st, 32'h0000_000A);
        bus_read(A_DIV, d);
        check("rst_div", d, 32'd434);
        bus_read(A_CTRL, d);
        check("rst_ctrl", d, 32'h3);
        bus_read(32'h2000_0004, d);
        check("unsel_read_holds", d, 32'h3);
        bus_write(32'h2000_000C, 32'd9);
        bus_write(32'h2000_0000, 32'h77);
        bus_read(A_DIV, d);
        check("unsel_write_div", d, 32'd434);
        bus_read(A_STAT, st);
        check("unsel_write_tx_empty", {31'd0, st[1]}, 32'd1);

        // Divisor clamp
        bus_write(A_DIV, 32'd1);
        bus_read(A_DIV, d);
        check("div_clamp", d, 32'd4);

        // TX waveform: 0x55 then 0xA3 at 8 clocks per bit
        div_cur = 8;
        bus_write(A_DIV, 32'd8);
        fork
            begin
                bus_write(A_DATA, 32'h55);
                bus_write(A_DATA, 32'hA3);
            end
            begin
                capture_frame(cb, cp, cs);
                check("tx_frame0_byte", {24'd0, cb}, 32'h55);
                check("tx_frame0_stop", {31'd0, cs}, 32'd1);
                capture_frame(cb, cp, cs);
                check("tx_frame1_byte", {24'd0, cb}, 32'hA3);
                check("tx_frame1_stop", {31'd0, cs}, 32'd1);
            end
        join
        wait_tx_idle("tx2");
        bus_read(A_STAT, st);
        check("tx2_empty_idle", st & 32'h12, 32'h02);

        // Loopback: fixed bytes then randomised rounds with random divisors
        loopback = 1'b1;
        exp_q = {8'h00, 8'hFF, 8'h3C};
        foreach (exp_q[i]) bus_write(A_DATA, {24'd0, exp_q[i]});
        wait_tx_idle("lb3");
        bus_read(A_STAT, st);
        check("lb3_rx_count", {24'd0, st[23:16]}, 32'd3);
        while (exp_q.size() > 0) begin
            bus_read(A_DATA, d);
            check("lb3_data", d, {24'd0, exp_q.pop_front()});
        end
        bus_read(A_DATA, d);
        check("lb3_empty_read", d, 32'd0);
        bus_read(A_STAT, st);
        check("lb3_rx_count_after", {24'd0, st[23:16]}, 32'd0);

        for (int r = 0; r < 6; r++) begin
            div_cur = $urandom_range(6, 16);
            bus_write(A_DIV, div_cur);
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_write(A_DATA, {24'd0, b});
            end
            wait_tx_idle("lbr");
            bus_read(A_STAT, st);
            check("lbr_rx_count", {24'd0, st[23:16]}, k);
            while (exp_q.size() > 0) begin
                bus_read(A_DATA, d);
                check("lbr_data", d, {24'd0, exp_q.pop_front()});
            end
        end

        // TX overflow with the transmitter halted, then RX fill and overrun
        div_cur = 8;
        bus_write(A_DIV, 32'd8);
        bus_write(A_CTRL, 32'h2);
        for (int j = 0; j <= DEPTH; j++) begin
            b = 8'($urandom);
            if (j < DEPTH) exp_q.push_back(b);
            bus_write(A_DATA, {24'd0, b});
        end
        bus_read(A_STAT, st);
        check("txovf_full_flag", st & 32'h103, 32'h101);
        bus_write(A_STAT, 32'h100);
        bus_read(A_STAT, st);
        check("txovf_w1c", st & 32'h101, 32'h001);
        bus_write(A_CTRL, 32'h3);
        wait_tx_idle("fill");
        bus_read(A_STAT, st);
        check("fill_rx_count", {24'd0, st[23:16]}, DEPTH);
        check("fill_rx_full_no_ovr", st & 32'h24, 32'h04);
        bus_write(A_DATA, 32'h5A);
        wait_tx_idle("ovr");
        bus_read(A_STAT, st);
        check("ovr_flag", st & 32'h24, 32'h24);
        check("ovr_rx_count", {24'd0, st[23:16]}, DEPTH);
        bus_write(A_STAT, 32'h20);
        bus_read(A_STAT, st);
        check("ovr_w1c", {31'd0, st[5]}, 32'd0);
        while (exp_q.size() > 0) begin
            bus_read(A_DATA, d);
            check("fill_data", d, {24'd0, exp_q.pop_front()});
        end

        // Bench-driven RX: good frame, framing error, false start
        loopback = 1'b0;
        b = 8'($urandom);
        drive_frame(b, 1'b0, 1'b0, 1'b1);
        drive_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        bus_read(A_STAT, st);
        check("ferr_flag", st & 32'h1E0, 32'h040);
        check("ferr_rx_count", {24'd0, st[23:16]}, 32'd1);
        bus_write(A_STAT, 32'h40);
        @(negedge clk_in);
        rx_drive = 1'b0;
        repeat (2) @(negedge clk_in);
        rx_drive = 1'b1;
        repeat (3 * div_cur) @(negedge clk_in);
        bus_read(A_STAT, st);
        check("false_start_flags", st & 32'h1E0, 32'h0);
        check("false_start_count", {24'd0, st[23:16]}, 32'd1);
        bus_read(A_DATA, d);
        check("ferr_good_byte", d, {24'd0, b});

`ifdef UART_PARITY_EN
        // Odd parity loopback and a corrupted parity bit
        bus_write(A_CTRL, 32'hF);
        par_on = 1'b1;
        loopback = 1'b1;
        fork
            bus_write(A_DATA, 32'h07);
            begin
                capture_frame(cb, cp, cs);
                check("par_tx_byte", {24'd0, cb}, 32'h07);
                check("par_tx_bit", {31'd0, cp}, 32'd0);
            end
        join
        wait_tx_idle("par");
        bus_read(A_DATA, d);
        check("par_rx_byte", d, 32'h07);
        loopback = 1'b0;
        b = 8'($urandom);
        drive_frame(b, 1'b1, ^b, 1'b1);
        bus_read(A_STAT, st);
        check("perr_flag", st & 32'h1E0, 32'h080);
        check("perr_rx_count", {24'd0, st[23:16]}, 32'd0);
        par_on = 1'b0;
        bus_write(A_STAT, 32'h80);
        bus_write(A_CTRL, 32'h3);
`else
        bus_write(A_CTRL, 32'hF);
        bus_read(A_CTRL, d);
        check("ctrl_no_parity", d, 32'h3);
        bus_write(A_CTRL, 32'h3);
`endif

        // Asynchronous reset in the middle of a TX frame
        loopback = 1'b1;
        bus_write(A_DATA, 32'h00);
        repeat (3 * div_cur) @(negedge clk_in);
        check("mid_frame_low", {31'd0, tx_pin}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check("async_rst_tx_pin", {31'd0, tx_pin}, 32'd1);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        bus_read(A_STAT, st);
        check("post_rst_status", st, 32'h0000_000A);
        bus_read(A_DIV, d);
        check("post_rst_div", d, 32'd434);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
